// File: rtl/int4_weight_unpacker.sv
// rtl/int4_weight_unpacker.sv - serialises packed INT4 weight words into tagged nibbles for the dequantizer
// Optional stall counter port stall_cycles is built when UNPACK_PERF_EN is defined.
module int4_weight_unpacker #(
  parameter int NIBBLES_PER_WORD = 8,
  parameter int GROUP_SIZE       = 32,
  parameter int CNT_W            = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  input  logic [CNT_W-1:0]              num_weights,
  input  logic                          word_valid,
  input  logic [4*NIBBLES_PER_WORD-1:0] word_data,
  output logic                          word_ready,
  input  logic                          grp_valid,
  input  logic [3:0]                    grp_scale,
  input  logic [3:0]                    grp_offset,
  output logic                          grp_ready,
  input  logic                          out_ready,
  output logic                          valid_out,
  output logic [3:0]                    int4_out,
  output logic [3:0]                    scale_out,
  output logic [3:0]                    offset_out,
  output logic                          last_out,
  output logic                          busy,
  output logic                          done
`ifdef UNPACK_PERF_EN
  ,
  output logic [31:0]                   stall_cycles
`endif
);

  localparam int NIB_W = $clog2(NIBBLES_PER_WORD + 1);
  localparam logic [NIB_W-1:0] NIB_EMPTY = NIB_W'(NIBBLES_PER_WORD);
  localparam logic [CNT_W-1:0] GRP_FULL  = CNT_W'(GROUP_SIZE);

  typedef enum logic [2:0] {
    S_IDLE,
    S_GRP,
    S_WORD,
    S_EMIT,
    S_DRAIN
  } state_t;

  state_t                        r_state;
  state_t                        w_next;
  logic [CNT_W-1:0]              r_remaining;
  logic [CNT_W-1:0]              r_grp_cnt;
  logic [NIB_W-1:0]              r_nib_idx;
  logic [4*NIBBLES_PER_WORD-1:0] r_word;
  logic [3:0]                    r_scale;
  logic [3:0]                    r_offset;
  logic                          r_valid_out;
  logic [3:0]                    r_int4_out;
  logic [3:0]                    r_scale_out;
  logic [3:0]                    r_offset_out;
  logic                          r_last_out;
  logic                          r_done;

  logic                          w_slot_free;
  logic                          w_load;
  logic                          w_accept;
  logic [CNT_W-1:0]              w_rem_dec;
  logic [CNT_W-1:0]              w_grp_inc;
  logic [NIB_W-1:0]              w_nib_inc;
  logic [3:0]                    w_nibble;

  assign w_slot_free = !r_valid_out || out_ready;
  assign w_load      = (r_state == S_EMIT) && w_slot_free;
  assign w_accept    = r_valid_out && out_ready;
  assign w_rem_dec   = r_remaining - 1'b1;
  assign w_grp_inc   = r_grp_cnt + 1'b1;
  assign w_nib_inc   = r_nib_idx + 1'b1;
  assign w_nibble    = 4'(r_word >> {r_nib_idx, 2'b00});

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next     = r_state;
    word_ready = 1'b0;
    grp_ready  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start && (num_weights != '0)) w_next = S_GRP;
      end
      S_GRP: begin
        grp_ready = 1'b1;
        if (grp_valid) w_next = (r_nib_idx != NIB_EMPTY) ? S_EMIT : S_WORD;
      end
      S_WORD: begin
        word_ready = 1'b1;
        if (word_valid) w_next = S_EMIT;
      end
      S_EMIT: begin
        // Group boundary wins over word exhaustion; GRP then falls through to WORD.
        if (w_load) begin
          if (w_rem_dec == '0)             w_next = S_DRAIN;
          else if (w_grp_inc == GRP_FULL)  w_next = S_GRP;
          else if (w_nib_inc == NIB_EMPTY) w_next = S_WORD;
        end
      end
      S_DRAIN: begin
        if (w_accept) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // r_nib_idx == NIB_EMPTY marks the word buffer as holding no unread nibbles.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_remaining  <= '0;
      r_grp_cnt    <= '0;
      r_nib_idx    <= NIB_EMPTY;
      r_word       <= '0;
      r_scale      <= '0;
      r_offset     <= '0;
      r_valid_out  <= 1'b0;
      r_int4_out   <= '0;
      r_scale_out  <= '0;
      r_offset_out <= '0;
      r_last_out   <= 1'b0;
      r_done       <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (r_state == S_IDLE && start) begin
        r_remaining <= num_weights;
        r_nib_idx   <= NIB_EMPTY;
        r_done      <= (num_weights == '0);
      end
      if (r_state == S_GRP && grp_valid) begin
        r_scale   <= grp_scale;
        r_offset  <= grp_offset;
        r_grp_cnt <= '0;
      end
      if (r_state == S_WORD && word_valid) begin
        r_word    <= word_data;
        r_nib_idx <= '0;
      end
      if (w_load) begin
        r_remaining  <= w_rem_dec;
        r_grp_cnt    <= w_grp_inc;
        r_nib_idx    <= w_nib_inc;
        r_valid_out  <= 1'b1;
        r_int4_out   <= w_nibble;
        r_scale_out  <= r_scale;
        r_offset_out <= r_offset;
        r_last_out   <= (w_rem_dec == '0);
      end else if (w_accept) begin
        r_valid_out <= 1'b0;
        r_last_out  <= 1'b0;
      end
      if (r_state == S_DRAIN && w_accept) r_done <= 1'b1;
    end
  end

  assign valid_out  = r_valid_out;
  assign int4_out   = r_int4_out;
  assign scale_out  = r_scale_out;
  assign offset_out = r_offset_out;
  assign last_out   = r_last_out;
  assign busy       = (r_state != S_IDLE);
  assign done       = r_done;

`ifdef UNPACK_PERF_EN
  logic [31:0] r_stall_cycles;
  logic        w_stall;

  assign w_stall = (r_state != S_IDLE) &&
                   ((r_valid_out && !out_ready) ||
                    (r_state == S_WORD && !word_valid) ||
                    (r_state == S_GRP && !grp_valid));

  always_ff @(posedge clk) begin
    if (rst || (r_state == S_IDLE && start)) r_stall_cycles <= '0;
    else if (w_stall && (r_stall_cycles != '1)) r_stall_cycles <= r_stall_cycles + 1'b1;
  end

  assign stall_cycles = r_stall_cycles;
`endif

endmodule

// File: tb/tb_int4_weight_unpacker.sv
// tb/tb_int4_weight_unpacker.sv - directed self-checking bench for int4_weight_unpacker (GROUP_SIZE=4)
module tb_int4_weight_unpacker;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [15:0] num_weights = '0;
  logic        word_valid = 1'b0;
  logic [31:0] word_data = '0;
  logic        word_ready;
  logic        grp_valid = 1'b0;
  logic [3:0]  grp_scale = '0;
  logic [3:0]  grp_offset = '0;
  logic        grp_ready;
  logic        out_ready = 1'b1;
  logic        valid_out;
  logic [3:0]  int4_out;
  logic [3:0]  scale_out;
  logic [3:0]  offset_out;
  logic        last_out;
  logic        busy;
  logic        done;
`ifdef UNPACK_PERF_EN
  logic [31:0] stall_cycles;
`endif

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  int4_weight_unpacker #(
    .NIBBLES_PER_WORD(8),
    .GROUP_SIZE(4),
    .CNT_W(16)
  ) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .num_weights(num_weights),
    .word_valid(word_valid),
    .word_data(word_data),
    .word_ready(word_ready),
    .grp_valid(grp_valid),
    .grp_scale(grp_scale),
    .grp_offset(grp_offset),
    .grp_ready(grp_ready),
    .out_ready(out_ready),
    .valid_out(valid_out),
    .int4_out(int4_out),
    .scale_out(scale_out),
    .offset_out(offset_out),
    .last_out(last_out),
    .busy(busy),
    .done(done)
`ifdef UNPACK_PERF_EN
    ,
    .stall_cycles(stall_cycles)
`endif
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic [3:0] n, input logic [3:0] s,
                         input logic [3:0] o, input logic l);
    chk({tag, "_valid"}, 32'(valid_out), 32'd1);
    chk({tag, "_int4"}, 32'(int4_out), 32'(n));
    chk({tag, "_scale"}, 32'(scale_out), 32'(s));
    chk({tag, "_offset"}, 32'(offset_out), 32'(o));
    chk({tag, "_last"}, 32'(last_out), 32'(l));
  endtask

  task automatic send_hdr(input logic [3:0] s, input logic [3:0] o);
    grp_valid = 1'b1; grp_scale = s; grp_offset = o;
    tick();
    grp_valid = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w);
    word_valid = 1'b1; word_data = w;
    tick();
    word_valid = 1'b0;
  endtask

  initial begin
    // Reset state
    tick(); tick();
    chk("rst_valid", 32'(valid_out), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_word_ready", 32'(word_ready), 0);
    chk("rst_grp_ready", 32'(grp_ready), 0);
    chk("rst_done", 32'(done), 0);
    rst = 1'b0;
    tick();

    // Group boundary mid-word: 8 weights, headers (1,0) then (5,9), one word
    start = 1'b1; num_weights = 16'd8;
    tick();
    start = 1'b0;
    chk("t1_grp_ready", 32'(grp_ready), 1);
    chk("t1_busy", 32'(busy), 1);
    send_hdr(4'd1, 4'd0);
    chk("t1_word_ready", 32'(word_ready), 1);
    chk("t1_grp_ready_lo", 32'(grp_ready), 0);
    send_word(32'hFEDC_BA98);
    chk("t1_latency", 32'(valid_out), 0);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk_out("t1_g0", 4'(8 + i), 4'd1, 4'd0, 1'b0);
    end
    chk("t1_grp_ready_mid", 32'(grp_ready), 1);
    send_hdr(4'd5, 4'd9);
    chk("t1_bubble", 32'(valid_out), 0);
    chk("t1_no_refetch", 32'(word_ready), 0);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk_out("t1_g1", 4'(12 + i), 4'd5, 4'd9, 1'(i == 3));
      chk("t1_no_refetch_emit", 32'(word_ready), 0);
    end
    tick();
    chk("t1_done", 32'(done), 1);
    chk("t1_idle", 32'(busy), 0);
    chk("t1_valid_clr", 32'(valid_out), 0);
    tick();
    chk("t1_done_pulse", 32'(done), 0);

    // Partial tail of 10 weights with backpressure on 0x5 and a start while busy
    start = 1'b1; num_weights = 16'd10;
    tick();
    start = 1'b0;
    send_hdr(4'd2, 4'd3);
    chk("t2_word_ready", 32'(word_ready), 1);
    send_word(32'h7654_3210);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk_out("t2_g0", 4'(i), 4'd2, 4'd3, 1'b0);
    end
    chk("t2_grp_ready1", 32'(grp_ready), 1);
    send_hdr(4'd4, 4'd5);
    chk("t2_bubble", 32'(valid_out), 0);
    tick();
    chk_out("t2_w4", 4'd4, 4'd4, 4'd5, 1'b0);
    tick();
    chk_out("t2_w5", 4'd5, 4'd4, 4'd5, 1'b0);
    out_ready = 1'b0;
    start = 1'b1; num_weights = 16'd3;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk_out("t2_hold", 4'd5, 4'd4, 4'd5, 1'b0);
    end
    out_ready = 1'b1;
    start = 1'b0;
    tick();
    chk_out("t2_w6", 4'd6, 4'd4, 4'd5, 1'b0);
    tick();
    chk_out("t2_w7", 4'd7, 4'd4, 4'd5, 1'b0);
    chk("t2_grp_ready2", 32'(grp_ready), 1);
    chk("t2_excl", 32'(word_ready), 0);
    send_hdr(4'd6, 4'd7);
    chk("t2_word_ready2", 32'(word_ready), 1);
    send_word(32'hFEDC_BA98);
    tick();
    chk_out("t2_w8", 4'd8, 4'd6, 4'd7, 1'b0);
    tick();
    chk_out("t2_w9", 4'd9, 4'd6, 4'd7, 1'b1);
    chk("t2_tail_dropped", 32'(word_ready), 0);
    tick();
    chk("t2_done", 32'(done), 1);
    chk("t2_idle", 32'(busy), 0);
    chk("t2_word_ready_end", 32'(word_ready), 0);
    tick();

    // num_weights = 0
    start = 1'b1; num_weights = 16'd0;
    tick();
    start = 1'b0;
    chk("t3_done", 32'(done), 1);
    chk("t3_busy", 32'(busy), 0);
    chk("t3_grp_ready", 32'(grp_ready), 0);
    chk("t3_word_ready", 32'(word_ready), 0);
    tick();
    chk("t3_done_pulse", 32'(done), 0);

    // Reset mid-run after 3 weights, then a clean replay
    start = 1'b1; num_weights = 16'd8;
    tick();
    start = 1'b0;
    send_hdr(4'd7, 4'd1);
    send_word(32'h1357_9BDF);
    tick(); tick(); tick();
    chk_out("t4_w2", 4'hB, 4'd7, 4'd1, 1'b0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("t4_valid", 32'(valid_out), 0);
    chk("t4_int4", 32'(int4_out), 0);
    chk("t4_scale", 32'(scale_out), 0);
    chk("t4_offset", 32'(offset_out), 0);
    chk("t4_busy", 32'(busy), 0);
    start = 1'b1; num_weights = 16'd2;
    tick();
    start = 1'b0;
    chk("t4_replay_grp", 32'(grp_ready), 1);
    send_hdr(4'd3, 4'd3);
    chk("t4_replay_word", 32'(word_ready), 1);
    send_word(32'h0000_00A5);
    tick();
    chk_out("t4_r0", 4'h5, 4'd3, 4'd3, 1'b0);
    tick();
    chk_out("t4_r1", 4'hA, 4'd3, 4'd3, 1'b1);
    tick();
    chk("t4_done", 32'(done), 1);
    tick();

`ifdef UNPACK_PERF_EN
    // 5 cycles waiting for a word plus 2 backpressured cycles
    start = 1'b1; num_weights = 16'd2;
    tick();
    start = 1'b0;
    send_hdr(4'd1, 4'd1);
    repeat (5) tick();
    send_word(32'h0000_0021);
    tick();
    chk_out("t5_w0", 4'h1, 4'd1, 4'd1, 1'b0);
    out_ready = 1'b0;
    tick(); tick();
    out_ready = 1'b1;
    tick();
    chk_out("t5_w1", 4'h2, 4'd1, 4'd1, 1'b1);
    tick();
    chk("t5_done", 32'(done), 1);
    chk("t5_stall", stall_cycles, 32'd7);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/int4_weight_unpacker.md
Name: int4_weight_unpacker

Overview:
Upstream feeder for the INT4→INT8 dequantizer stage. It accepts packed 32-bit weight words and per-group scale/offset headers through valid/ready handshakes. It serialises the words into one 4-bit weight per cycle, each tagged with its group's scale and offset, ready to drive the dequantizer's valid_in/int4_in/scale/offset inputs. A run of num_weights weights is launched by start; done pulses when the last weight is accepted downstream.

Parameters:
NIBBLES_PER_WORD, 8, nibbles per input word; word width = 4*NIBBLES_PER_WORD.
GROUP_SIZE, 32, weights sharing one scale/offset header (≥1; need not divide NIBBLES_PER_WORD).
CNT_W, 16, width of weight-count and group counters.

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
start  in  1  launch run; sampled only in IDLE
num_weights  in  CNT_W  weights in run; latched on start
word_valid  in  1  packed word available
word_data  in  4*NIBBLES_PER_WORD  packed weights, nibble 0 in bits [3:0]
word_ready  out  1  unpacker accepts word this cycle
grp_valid  in  1  group header available
grp_scale  in  4  group scale
grp_offset  in  4  group zero-point
grp_ready  out  1  unpacker accepts header this cycle
out_ready  in  1  downstream accepts weight (tie 1 for the dequantizer)
valid_out  out  1  int4_out/scale_out/offset_out valid
int4_out  out  4  weight nibble
scale_out  out  4  scale of that weight's group
offset_out  out  4  offset of that weight's group
last_out  out  1  final weight of run
busy  out  1  high in any state but IDLE
done  out  1  one-cycle pulse on acceptance of final weight

Behaviour:
- Reset is synchronous and active-high on rst, with one clock clk. All state, counters and buffers clear, and the FSM returns to IDLE. Outputs reset to 0: valid_out, last_out, busy, done, word_ready, grp_ready, int4_out, scale_out, offset_out. Reset mid-run discards the buffered word and any pending output.
- FSM states:
  - IDLE: start=1 and num_weights>0 → GRP. start=1 and num_weights=0 → done pulses the next cycle, stays IDLE, no handshakes.
  - GRP: grp_ready=1. On grp_valid, latch scale/offset and clear grp_cnt. If nibbles remain in the word buffer → EMIT, else → WORD.
  - WORD: word_ready=1. On word_valid, latch word_data and set nib_idx=0 → EMIT.
  - EMIT: loads one nibble into the output register whenever the slot is free (valid_out=0 or out_ready=1). On load: remaining−1, grp_cnt+1, nib_idx+1.
    - remaining reaches 0 → DRAIN, with last_out=1 on that weight.
    - Else grp_cnt reaches GROUP_SIZE → GRP.
    - Else nib_idx reaches NIBBLES_PER_WORD → WORD.
  - DRAIN: when valid_out && out_ready, done=1 for one cycle and the FSM goes to IDLE on the same edge.
- Output register hold: while valid_out=1 and out_ready=0, int4_out, scale_out, offset_out and last_out are held stable. The register clears valid_out on acceptance if no new nibble loads in the same cycle.
- An accepted output may remain pending while the FSM sits in GRP or WORD. Header/word fetch overlaps the final-weight handshake.
- Throughput: 1 weight/cycle within a word. There is a minimum 1-cycle bubble per word fetch and per header fetch.
- The unused tail nibbles of the last word are discarded. word_ready and grp_ready are never both high.
- start is ignored while busy=1. A group boundary that falls mid-word preserves the remaining nibbles of the buffered word.
- Latency: from word accept to first valid_out is 1 cycle (EMIT loads on the cycle after the WORD handshake).

Optional Feature:
UNPACK_PERF_EN.
- Defined: adds output port stall_cycles [31:0], cleared by rst and by start. It increments each cycle that busy=1 and either (valid_out=1 && out_ready=0), or the FSM is in WORD/GRP with no handshake. It saturates at 0xFFFFFFFF.
- Undefined: the port and counter are absent; the rest of the behaviour is identical.

Test Plan:
- Basic run, GROUP_SIZE=8: num_weights=8, header scale=3/offset=2, word 0x76543210, out_ready=1 → int4_out 0,1,…,7 on 8 consecutive cycles, all tagged scale=3/offset=2, last_out on 7, done 1 cycle after.
- Group boundary mid-word, GROUP_SIZE=4: num_weights=8, headers (1,0) then (5,9), word 0xFEDCBA98 → nibbles 8–B tagged (1,0); grp_ready asserted before C; C–F tagged (5,9); no word refetch.
- Partial tail: num_weights=10 → 2 words consumed; nibbles 2–7 of the second word are dropped; word_ready stays 0 after the second word; last_out on weight 9.
- Backpressure: out_ready low for 3 cycles while int4_out=0x5 → outputs are stable all 3 cycles, no nibble is lost or duplicated, and the sequence resumes with 0x6.
- Edge cases: num_weights=0 → done the next cycle with no word_ready/grp_ready. rst asserted mid-run after 3 weights → all outputs 0 the next cycle; a new start replays cleanly from header fetch.
- UNPACK_PERF_EN: word_valid withheld 5 cycles in WORD, plus 2 cycles with out_ready=0 → stall_cycles=7 at done.
